// File: rtl/uart_rx_framed_if.sv
`default_nettype none
// =============================================================================
// Module   : uart_rx_framed_if
// Brief    : Received-frame bus of uart_rx_framed: one-cycle strobe plus the
//            data byte and error flags that are held until the next strobe.
// Revision : 1.0
// =============================================================================
interface uart_rx_framed_if #(
    parameter int DATA_BITS = 8
);
    logic                 o_RX_DV;
    logic [DATA_BITS-1:0] o_RX_Byte;
    logic                 o_Parity_Err;
    logic                 o_Frame_Err;
    logic                 o_Break;

    modport master (
        output o_RX_DV,
        output o_RX_Byte,
        output o_Parity_Err,
        output o_Frame_Err,
        output o_Break
    );

    modport slave (
        input o_RX_DV,
        input o_RX_Byte,
        input o_Parity_Err,
        input o_Frame_Err,
        input o_Break
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_framed.sv
`default_nettype none
// =============================================================================
// Module   : uart_rx_framed
// Brief    : UART receiver, 5..9 data bits, none/odd/even parity, 1 or 2 stop
//            bits, with parity/framing/break flags. Optional build macro
//            UART_RX_MAJORITY_EN selects 2-of-3 majority sampling.
// Revision : 1.0
// =============================================================================
module uart_rx_framed #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_RX_Serial,
    uart_rx_framed_if.master rx_if
);
    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W = $clog2(DATA_BITS + 1);
    localparam int c_MID   = (CLKS_PER_BIT - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int c_MAJ_DLY = 1;
`else
    localparam int c_MAJ_DLY = 0;
`endif
    localparam logic [c_CNT_W-1:0] c_START_PT  = c_CNT_W'(c_MID + c_MAJ_DLY);
    localparam logic [c_CNT_W-1:0] c_BIT_END   = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_DATA = c_IDX_W'(DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_STOP = c_IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_CLEANUP = 3'd5
    } state_t;

    state_t               state_q;
    logic                 rx_meta_q;
    logic                 rx_s_q;
    logic [c_CNT_W-1:0]   cnt_q;
    logic [c_IDX_W-1:0]   idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 ones_q;
    logic                 frm_err_q;
    logic                 par_err_q;
    logic                 brk_wait_q;
    logic                 dv_q;
    logic [DATA_BITS-1:0] byte_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 brk_q;
    logic                 w_bit;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_RX_Serial;
            rx_s_q    <= rx_meta_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Two delayed copies give samples s-1, s, s+1; every decision point is
    // pushed one cycle later through c_MAJ_DLY on the start validation.
    logic rx_h1_q;
    logic rx_h2_q;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_h1_q <= 1'b1;
            rx_h2_q <= 1'b1;
        end else begin
            rx_h1_q <= rx_s_q;
            rx_h2_q <= rx_h1_q;
        end
    end

    assign w_bit = (rx_s_q & rx_h1_q) | (rx_s_q & rx_h2_q) | (rx_h1_q & rx_h2_q);
`else
    assign w_bit = rx_s_q;
`endif

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            ones_q     <= 1'b0;
            frm_err_q  <= 1'b0;
            par_err_q  <= 1'b0;
            brk_wait_q <= 1'b0;
            dv_q       <= 1'b0;
            byte_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    // After a break the line must be seen high before a new start.
                    if (brk_wait_q) begin
                        if (rx_s_q) brk_wait_q <= 1'b0;
                    end else if (!rx_s_q) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == c_START_PT) begin
                        cnt_q <= '0;
                        if (!w_bit) begin
                            state_q   <= S_DATA;
                            idx_q     <= '0;
                            ones_q    <= 1'b0;
                            frm_err_q <= 1'b0;
                            par_err_q <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == c_BIT_END) begin
                        cnt_q   <= '0;
                        shift_q <= {w_bit, shift_q[DATA_BITS-1:1]};
                        ones_q  <= ones_q | w_bit;
                        if (idx_q == c_LAST_DATA) begin
                            idx_q   <= '0;
                            state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (cnt_q == c_BIT_END) begin
                        cnt_q     <= '0;
                        ones_q    <= ones_q | w_bit;
                        par_err_q <= (PARITY == 1) ? ~(^shift_q ^ w_bit) : (^shift_q ^ w_bit);
                        state_q   <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == c_BIT_END) begin
                        cnt_q <= '0;
                        if (idx_q == c_LAST_STOP) begin
                            // Deliver mid-stop-bit so a back-to-back start edge is not missed.
                            idx_q      <= '0;
                            dv_q       <= 1'b1;
                            byte_q     <= shift_q;
                            perr_q     <= (PARITY != 0) && par_err_q;
                            ferr_q     <= frm_err_q | ~w_bit;
                            brk_q      <= ~(ones_q | w_bit);
                            brk_wait_q <= ~(ones_q | w_bit);
                            state_q    <= S_CLEANUP;
                        end else begin
                            idx_q     <= idx_q + 1'b1;
                            frm_err_q <= frm_err_q | ~w_bit;
                            ones_q    <= ones_q | w_bit;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_CLEANUP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_if.o_RX_DV      = dv_q;
    assign rx_if.o_RX_Byte    = byte_q;
    assign rx_if.o_Parity_Err = perr_q;
    assign rx_if.o_Frame_Err  = ferr_q;
    assign rx_if.o_Break      = brk_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_framed.sv
`default_nettype none
// =============================================================================
// Module   : tb_uart_rx_framed
// Brief    : Bench for uart_rx_framed: 8N1, 7E1 and 8N2 receivers at 16 clocks
//            per bit, directed and random frames against a frame-level model.
// Revision : 1.0
// =============================================================================
module tb_uart_rx_framed;
    localparam int CPB  = 16;
    localparam int MIDC = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;
    logic rx2 = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Entry layout: {break, frame_err, parity_err, byte[8:0]}
    logic [11:0] obs0[$];
    logic [11:0] obs1[$];
    logic [11:0] obs2[$];
    logic [11:0] exp0[$];
    logic [11:0] exp1[$];
    logic [11:0] exp2[$];

    always #5 clk = ~clk;

    uart_rx_framed_if #(.DATA_BITS(8)) if0 ();
    uart_rx_framed_if #(.DATA_BITS(7)) if1 ();
    uart_rx_framed_if #(.DATA_BITS(8)) if2 ();

    uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(rx0), .rx_if(if0.master));
    uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_dut1 (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(rx1), .rx_if(if1.master));
    uart_rx_framed #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_dut2 (
        .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(rx2), .rx_if(if2.master));

    always @(negedge clk) begin
        if (if0.o_RX_DV) obs0.push_back({if0.o_Break, if0.o_Frame_Err, if0.o_Parity_Err, 9'(if0.o_RX_Byte)});
        if (if1.o_RX_DV) obs1.push_back({if1.o_Break, if1.o_Frame_Err, if1.o_Parity_Err, 9'(if1.o_RX_Byte)});
        if (if2.o_RX_DV) obs2.push_back({if2.o_Break, if2.o_Frame_Err, if2.o_Parity_Err, 9'(if2.o_RX_Byte)});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_line(input int sel, input logic v);
        case (sel)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    task automatic idle(input int sel, input int bits);
        set_line(sel, 1'b1);
        tick(bits * CPB);
    endtask

    function automatic int db_of(input int sel);
        return (sel == 1) ? 7 : 8;
    endfunction

    function automatic int par_of(input int sel);
        return (sel == 1) ? 2 : 0;
    endfunction

    function automatic int sb_of(input int sel);
        return (sel == 2) ? 2 : 1;
    endfunction

    task automatic push_exp(input int sel, input logic [11:0] e);
        case (sel)
            0:       exp0.push_back(e);
            1:       exp1.push_back(e);
            default: exp2.push_back(e);
        endcase
    endtask

    // Builds the serial frame, predicts the receiver result from the frame
    // content alone, then drives every level for a full bit period.
    task automatic send(input int sel, input logic [8:0] data, input bit flip,
                        input logic [1:0] stops, input int glitch);
        int         db, par, sb, n, ones;
        logic [15:0] lv;
        logic [8:0]  d;
        logic        pe, fe, brk;
        db  = db_of(sel);
        par = par_of(sel);
        sb  = sb_of(sel);
        d   = data & ((9'd1 << db) - 9'd1);
        lv  = '0;
        n   = 1;
        for (int i = 0; i < db; i++) begin
            lv[n] = d[i];
            n++;
        end
        if (par != 0) begin
            lv[n] = (par == 2) ? ^d : ~^d;
            if (flip) lv[n] = ~lv[n];
            n++;
        end
        for (int i = 0; i < sb; i++) begin
            lv[n] = stops[i];
            n++;
        end
        ones = 0;
        for (int i = 1; i <= db + ((par != 0) ? 1 : 0); i++) ones += int'(lv[i]);
        pe = (par == 1 && ones % 2 == 0) || (par == 2 && ones % 2 == 1);
        fe = 1'b0;
        for (int i = 0; i < sb; i++) if (!stops[i]) fe = 1'b1;
        brk = 1'b1;
        for (int i = 1; i < n; i++) if (lv[i]) brk = 1'b0;
        push_exp(sel, {brk, fe, pe, d});
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < CPB; j++) begin
                set_line(sel, (i == glitch && j == MIDC) ? 1'b0 : lv[i]);
                tick(1);
            end
        end
    endtask

    task automatic check_q(input int sel, input string tag);
        logic [11:0] o[$];
        logic [11:0] e[$];
        case (sel)
            0: begin o = obs0; e = exp0; obs0.delete(); exp0.delete(); end
            1: begin o = obs1; e = exp1; obs1.delete(); exp1.delete(); end
            default: begin o = obs2; e = exp2; obs2.delete(); exp2.delete(); end
        endcase
        check({tag, "_count"}, 32'(o.size()), 32'(e.size()));
        for (int i = 0; i < o.size() && i < e.size(); i++) check(tag, 32'(o[i]), 32'(e[i]));
    endtask

    logic [7:0] v3c;

    initial begin
        tick(4);
        check("reset_dut0", 32'({if0.o_RX_DV, if0.o_Break, if0.o_Frame_Err, if0.o_Parity_Err, if0.o_RX_Byte}), 32'd0);
        check("reset_dut1", 32'({if1.o_RX_DV, if1.o_Break, if1.o_Frame_Err, if1.o_Parity_Err, if1.o_RX_Byte}), 32'd0);
        check("reset_dut2", 32'({if2.o_RX_DV, if2.o_Break, if2.o_Frame_Err, if2.o_Parity_Err, if2.o_RX_Byte}), 32'd0);
        rst = 1'b0;
        tick(4);

        send(0, 9'h0A5, 1'b0, 2'b11, -1);
        idle(0, 2);
        check_q(0, "8n1_a5");

        send(1, 9'h041, 1'b0, 2'b11, -1);
        idle(1, 2);
        check_q(1, "7e1_good");
        send(1, 9'h041, 1'b1, 2'b11, -1);
        idle(1, 2);
        check_q(1, "7e1_bad_parity");

        send(2, 9'h0C3, 1'b0, 2'b01, -1);
        idle(2, 2);
        check_q(2, "8n2_stop2_low");

        // Line held low for two whole frames: exactly one all-zero break frame.
        set_line(2, 1'b0);
        tick(2 * 11 * CPB);
        push_exp(2, {1'b1, 1'b1, 1'b0, 9'h000});
        idle(2, 3);
        check_q(2, "8n2_break");
        send(2, 9'h05A, 1'b0, 2'b11, -1);
        idle(2, 2);
        check_q(2, "8n2_after_break");

        set_line(0, 1'b0);
        tick(3);
        idle(0, 12);
        check_q(0, "glitch_false_start");

`ifdef UART_RX_MAJORITY_EN
        send(0, 9'h0FF, 1'b0, 2'b11, 4);
        idle(0, 2);
        check_q(0, "majority_glitch");
`endif

        send(0, 9'h000, 1'b0, 2'b11, -1);
        send(0, 9'h0FF, 1'b0, 2'b11, -1);
        send(0, 9'h055, 1'b0, 2'b11, -1);
        idle(0, 2);
        check_q(0, "back_to_back");

        // Reset during the 4th data bit of 0x3C.
        v3c = 8'h3C;
        set_line(0, 1'b0);
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            set_line(0, v3c[i]);
            tick(CPB);
        end
        set_line(0, v3c[3]);
        tick(CPB / 2);
        rst = 1'b1;
        tick(1);
        check("reset_mid_frame", 32'({if0.o_RX_DV, if0.o_Break, if0.o_Frame_Err, if0.o_Parity_Err, if0.o_RX_Byte}), 32'd0);
        rst = 1'b0;
        idle(0, 12);
        check_q(0, "reset_no_dv");
        send(0, 9'h03C, 1'b0, 2'b11, -1);
        idle(0, 2);
        check_q(0, "after_reset_3c");

        for (int k = 0; k < 20; k++) begin
            send(0, 9'($urandom_range(0, 255)), 1'b0, 2'b11, -1);
            if ($urandom_range(0, 1) == 1) idle(0, 1);
        end
        idle(0, 2);
        check_q(0, "rand_8n1");

        for (int k = 0; k < 20; k++) begin
            send(1, 9'($urandom_range(0, 127)), ($urandom_range(0, 3) == 0),
                 {1'b1, ($urandom_range(0, 4) != 0)}, -1);
            idle(1, int'($urandom_range(1, 2)));
        end
        tick(2);
        check_q(1, "rand_7e1");

        for (int k = 0; k < 20; k++) begin
            send(2, 9'($urandom_range(0, 255)), 1'b0,
                 {($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0)}, -1);
            idle(2, int'($urandom_range(1, 2)));
        end
        tick(2);
        check_q(2, "rand_8n2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
